bit_serial_comp: RTL and testbench
==================================

Name: bit_serial_comp

Overview:
Bit-serial magnitude/equality comparator for two unsigned WIDTH-bit operands streamed MSB-first, one bit of each per accepted cycle. It consumes the per-bit equality output of the gate-level 1-bit comparator stage. A small FSM then resolves the first differing bit into a registered eq/gt/lt result. It sits between serial operand sources (shift registers or serial links) and control logic needing a compare verdict without a parallel WIDTH-bit comparator.

Parameters:
WIDTH, 8, operand length in bits; legal range 2..64.
CNT_W, $clog2(WIDTH), width of the bit counter; derived, not overridden.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
start  input  1  begins a new comparison; clears result and counter.
bit_valid  input  1  a_bit/b_bit carry the next operand bit this cycle.
a_bit  input  1  current bit of operand A, MSB first.
b_bit  input  1  current bit of operand B, MSB first.
busy  output  1  high while in COMPARE.
done  output  1  one-cycle pulse when the result becomes valid.
eq  output  1  A == B; valid from done, held until the next start or reset.
gt  output  1  A > B; same validity as eq.
lt  output  1  A < B; same validity as eq.
bit_count  output  CNT_W  number of bits accepted so far in the current operation.

Behaviour:
- Reset values: busy=0, done=0, eq=0, gt=0, lt=0, bit_count=0, state=IDLE, internal decided=0, internal a_gt=0.
- FSM states:
  - IDLE: start -> COMPARE.
  - COMPARE: accepted bit with bit_count==WIDTH-1 -> DONE; start -> restart in COMPARE.
  - DONE: lasts exactly one cycle, done=1, then -> IDLE. start in DONE -> COMPARE.
- start, in any state: next cycle bit_count=0, decided=0, eq/gt/lt=0, state=COMPARE.
  - start has priority over bit_valid. A bit presented in the same cycle as start is dropped.
- Bit acceptance: only in COMPARE with bit_valid=1. bit_valid is ignored in IDLE and DONE.
- Gaps with bit_valid=0 are unlimited; state and counter are held during a gap.
- On each accepted bit:
  - bit_count increments.
  - If decided=0 and bit_eq=0, where bit_eq = XNOR(a_bit, b_bit) from the 1-bit comparator cell: set decided=1 and a_gt=a_bit.
  - Once decided=1, later bits do not alter the verdict.
- On the transition into DONE, registered from the final decided/a_gt values including the last bit:
  - eq = ~decided.
  - gt = decided & a_gt.
  - lt = decided & ~a_gt.
  - Exactly one of eq/gt/lt is high. All three are 0 while busy.
- Latency: done asserts the cycle after the WIDTH-th accepted bit. bit_count reads WIDTH-1 wraps? No: bit_count saturates at WIDTH-1 and is cleared only by start or reset. busy drops in the same cycle done rises.
- Reset mid-operation aborts immediately; no done pulse is generated.
- Back-to-back operation: start may be asserted in the done cycle. Results clear on the following cycle.

Optional Feature:
Macro EARLY_TERM_EN.
- Defined: on the first accepted differing bit, go to DONE immediately. done pulses the next cycle with gt/lt set; bit_count holds the number of bits consumed. Remaining stream bits are ignored until the next start. Equal operands still take WIDTH bits.
- Undefined: all WIDTH bits are always consumed. Latency is fixed, independent of the data.

Decomposition:
- Shared package/header (comp_pkg): FSM state encodings ST_IDLE=2'd0, ST_COMPARE=2'd1, ST_DONE=2'd2, and the result encoding constants.
- One sub-module: instantiate the existing gate-level comp_1_bit cell (i0=a_bit, i1=b_bit, op=bit_eq) for the per-bit equality. The FSM, counter and verdict registers stay in this module.

Test Plan:
- Reset mid-stream: assert reset after 3 accepted bits -> all outputs 0, state IDLE, no done pulse.
- WIDTH=8, A=0xA5, B=0xA5, bit_valid continuous -> done on cycle 9 after start, eq=1, gt=0, lt=0, bit_count=7.
- A=0x80, B=0x7F -> gt=1. With EARLY_TERM_EN: done 1 cycle after the first bit, bit_count=1. Without it: done after 8 bits.
- A=0x3C, B=0x3D, bit_valid toggling 1/0 -> lt=1 after 8 accepted bits; gaps do not advance bit_count.
- start asserted again after 4 bits of A=0xFF/B=0x00, then A=B=0x11 streamed -> eq=1; the earlier mismatch is discarded.
- start coincident with bit_valid, then 8 bits -> the coincident bit is dropped. start in the done cycle -> next operation runs cleanly, eq/gt/lt=0 while busy.

Source files
------------

// File: rtl/bit_serial_comp_pkg.sv
// Shared definitions for the bit-serial comparator: FSM state encoding,
// the {eq,gt,lt} result encoding and the helper that maps a verdict onto it.
package bit_serial_comp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    // Result bits are ordered {eq, gt, lt}
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_EQ   = 3'b100;
    localparam logic [2:0] RES_GT   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b001;

    function automatic logic [2:0] verdict(input logic decided, input logic a_gt);
        logic [2:0] res;
        if (!decided) begin
            res = RES_EQ;
        end else if (a_gt) begin
            res = RES_GT;
        end else begin
            res = RES_LT;
        end
        return res;
    endfunction

endpackage

// File: rtl/bit_serial_comp_if.sv
// Serial operand stream and compare-verdict bundle of bit_serial_comp.
interface bit_serial_comp_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH);

    logic             start;
    logic             bit_valid;
    logic             a_bit;
    logic             b_bit;
    logic             busy;
    logic             done;
    logic             eq;
    logic             gt;
    logic             lt;
    logic [CNT_W-1:0] bit_count;

    modport master (
        output start, bit_valid, a_bit, b_bit,
        input  busy, done, eq, gt, lt, bit_count
    );

    modport slave (
        input  start, bit_valid, a_bit, b_bit,
        output busy, done, eq, gt, lt, bit_count
    );

endinterface

// File: rtl/comp_1_bit.sv
// Gate-level 1-bit equality cell: op is high when i0 and i1 match.
module comp_1_bit (
    input  logic i0,
    input  logic i1,
    output logic op
);

    xnor g_xnor (op, i0, i1);

endmodule

// File: rtl/bit_serial_comp.sv
// Bit-serial MSB-first magnitude/equality comparator with registered eq/gt/lt.
// Optional macro EARLY_TERM_EN ends the operation at the first differing bit.
module bit_serial_comp
    import bit_serial_comp_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic            clk,
    input  logic            reset,
    bit_serial_comp_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 32'd1);

    state_e           state_r, state_nx_s;
    logic [CNT_W-1:0] cnt_r, cnt_nx_s;
    logic             decided_r, decided_nx_s;
    logic             a_gt_r, a_gt_nx_s;
    logic [2:0]       res_r, res_nx_s;
    logic             busy_r;
    logic             done_r;
    logic             bit_eq_s;
    logic             dec_bit_s;
    logic             agt_bit_s;
    logic             last_s;

    comp_1_bit u_cell (
        .i0 (bus.a_bit),
        .i1 (bus.b_bit),
        .op (bit_eq_s)
    );

    // Next-state, counter and verdict logic; start overrides everything
    always_comb begin
        state_nx_s   = state_r;
        cnt_nx_s     = cnt_r;
        decided_nx_s = decided_r;
        a_gt_nx_s    = a_gt_r;
        res_nx_s     = res_r;

        if (!decided_r && !bit_eq_s) begin
            dec_bit_s = 1'b1;
            agt_bit_s = bus.a_bit;
        end else begin
            dec_bit_s = decided_r;
            agt_bit_s = a_gt_r;
        end

`ifdef EARLY_TERM_EN
        last_s = (cnt_r == CNT_MAX) || (!decided_r && !bit_eq_s);
`else
        last_s = (cnt_r == CNT_MAX);
`endif

        if (bus.start) begin
            state_nx_s   = ST_COMPARE;
            cnt_nx_s     = '0;
            decided_nx_s = 1'b0;
            a_gt_nx_s    = 1'b0;
            res_nx_s     = RES_NONE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nx_s = ST_IDLE;
                end
                ST_COMPARE: begin
                    if (bus.bit_valid) begin
                        cnt_nx_s     = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_W'(1'b1);
                        decided_nx_s = dec_bit_s;
                        a_gt_nx_s    = agt_bit_s;
                        if (last_s) begin
                            state_nx_s = ST_DONE;
                            res_nx_s   = verdict(dec_bit_s, agt_bit_s);
                        end else begin
                            state_nx_s = ST_COMPARE;
                        end
                    end else begin
                        state_nx_s = ST_COMPARE;
                    end
                end
                ST_DONE: begin
                    state_nx_s = ST_IDLE;
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Datapath and registered status outputs derived from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r     <= '0;
            decided_r <= 1'b0;
            a_gt_r    <= 1'b0;
            res_r     <= RES_NONE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            cnt_r     <= cnt_nx_s;
            decided_r <= decided_nx_s;
            a_gt_r    <= a_gt_nx_s;
            res_r     <= res_nx_s;
            busy_r    <= (state_nx_s == ST_COMPARE);
            done_r    <= (state_nx_s == ST_DONE);
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.eq        = res_r[2];
    assign bus.gt        = res_r[1];
    assign bus.lt        = res_r[0];
    assign bus.bit_count = cnt_r;

endmodule

// File: tb/tb_bit_serial_comp.sv
// Self-checking bench for bit_serial_comp: integer-level reference model checked
// every cycle plus hand-computed latency/verdict expectations per scenario.
module tb_bit_serial_comp;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH);

`ifdef EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bit_serial_comp_if #(.WIDTH(WIDTH)) bus ();

    bit_serial_comp #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_edge = 0;
    bit model_on = 1'b0;

    // Reference model state: accumulated operand prefixes as integers
    logic        m_busy, m_done;
    logic [2:0]  m_res;
    int          m_n;
    logic [63:0] m_a, m_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Model update from the inputs presented at this edge
    always @(posedge clk) begin : model
        logic [63:0] na, nb;
        int          nn;
        bit          fin;
        if (reset) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_res <= 3'b000;
            m_n <= 0; m_a <= 64'd0; m_b <= 64'd0;
        end else if (bus.start) begin
            m_busy <= 1'b1; m_done <= 1'b0; m_res <= 3'b000;
            m_n <= 0; m_a <= 64'd0; m_b <= 64'd0;
        end else if (m_busy && bus.bit_valid) begin
            na  = {m_a[62:0], bus.a_bit};
            nb  = {m_b[62:0], bus.b_bit};
            nn  = m_n + 1;
            fin = (nn == WIDTH) || (EARLY && (na != nb));
            m_a <= na; m_b <= nb; m_n <= nn;
            if (fin) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                if (na > nb)      m_res <= 3'b010;
                else if (na < nb) m_res <= 3'b001;
                else              m_res <= 3'b100;
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    // Per-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        int ecount;
        if (model_on) begin
            ecount = (m_n > WIDTH - 1) ? WIDTH - 1 : m_n;
            check("cycle_outputs",
                  {24'd0, bus.busy, bus.done, bus.eq, bus.gt, bus.lt, bus.bit_count},
                  {24'd0, m_busy, m_done, m_res, CNT_W'(ecount)});
        end
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_edge = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(output int se);
        bus.start = 1'b1;
        bus.bit_valid = 1'b0;
        tick();
        bus.start = 1'b0;
        se = cyc;
    endtask

    task automatic stream(input logic [7:0] a, input logic [7:0] b, input int nbits, input bit gaps);
        for (int i = 7; i > 7 - nbits; i--) begin
            bus.bit_valid = 1'b1;
            bus.a_bit = a[i];
            bus.b_bit = b[i];
            tick();
            if (gaps) begin
                bus.bit_valid = 1'b0;
                tick();
            end
        end
        bus.bit_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int dc0, input int se, output int lat);
        for (int k = 0; k < 40 && done_cnt == dc0; k++) tick();
        if (done_cnt == dc0) check({name, "_timeout"}, 32'd0, 32'd1);
        lat = done_edge - se;
    endtask

    task automatic check_result(input string name, input logic [2:0] exp_res,
                                input int exp_lat, input int lat, input int exp_cnt);
        check({name, "_res"}, {29'd0, bus.eq, bus.gt, bus.lt}, {29'd0, exp_res});
        check({name, "_lat"}, lat, exp_lat);
        check({name, "_count"}, {29'd0, bus.bit_count}, exp_cnt);
    endtask

    initial begin
        int se, lat, dc0;
        reset = 1'b1;
        bus.start = 1'b0; bus.bit_valid = 1'b0; bus.a_bit = 1'b0; bus.b_bit = 1'b0;
        tick();
        model_on = 1'b1;
        tick(); tick();
        check("reset_state", {24'd0, bus.busy, bus.done, bus.eq, bus.gt, bus.lt, bus.bit_count}, 32'd0);
        reset = 1'b0;
        tick();

        // Reset after three accepted equal bits: no done pulse
        dc0 = done_cnt;
        do_start(se);
        stream(8'hA0, 8'hA0, 3, 1'b0);
        check("mid_busy", {31'd0, bus.busy}, 32'd1);
        check("mid_count", {29'd0, bus.bit_count}, 32'd3);
        reset = 1'b1; tick(); reset = 1'b0;
        check("abort_outputs", {24'd0, bus.busy, bus.done, bus.eq, bus.gt, bus.lt, bus.bit_count}, 32'd0);
        tick(); tick();
        check("abort_no_done", done_cnt, dc0);

        // Equal operands, continuous stream
        dc0 = done_cnt;
        do_start(se);
        stream(8'hA5, 8'hA5, 8, 1'b0);
        wait_done("a5", dc0, se, lat);
        check_result("a5", 3'b100, 8, lat, 7);

        // MSB decides A > B
        dc0 = done_cnt;
        do_start(se);
        stream(8'h80, 8'h7F, 8, 1'b0);
        wait_done("80_7f", dc0, se, lat);
        check_result("80_7f", 3'b010, EARLY ? 1 : 8, lat, EARLY ? 1 : 7);

        // LSB decides A < B, with a gap after every bit
        dc0 = done_cnt;
        do_start(se);
        stream(8'h3C, 8'h3D, 8, 1'b1);
        wait_done("3c_3d", dc0, se, lat);
        check_result("3c_3d", 3'b001, EARLY ? 15 : 15, lat, 7);

        // Restart mid-operation discards the earlier mismatch
        do_start(se);
        stream(8'hFF, 8'h00, 4, 1'b0);
        dc0 = done_cnt;
        do_start(se);
        stream(8'h11, 8'h11, 8, 1'b0);
        wait_done("restart", dc0, se, lat);
        check_result("restart", 3'b100, 8, lat, 7);

        // Bit coincident with start is dropped
        dc0 = done_cnt;
        bus.start = 1'b1; bus.bit_valid = 1'b1; bus.a_bit = 1'b1; bus.b_bit = 1'b0;
        tick();
        bus.start = 1'b0; bus.bit_valid = 1'b0;
        se = cyc;
        stream(8'h00, 8'h00, 8, 1'b0);
        check("coinc_done_now", {31'd0, bus.done}, 32'd1);
        check("coinc_res", {29'd0, bus.eq, bus.gt, bus.lt}, 32'd4);

        // start in the done cycle: results clear and a clean op follows
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        se = cyc;
        check("b2b_busy", {31'd0, bus.busy}, 32'd1);
        check("b2b_cleared", {29'd0, bus.eq, bus.gt, bus.lt}, 32'd0);
        check("b2b_count", {29'd0, bus.bit_count}, 32'd0);
        dc0 = done_cnt;
        stream(8'h01, 8'h02, 8, 1'b0);
        wait_done("b2b", dc0, se, lat);
        check_result("b2b", 3'b001, EARLY ? 7 : 8, lat, EARLY ? 7 : 7);

        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
